tiny_cpu_mc: RTL and testbench
==============================

Name: tiny_cpu_mc

Overview:
Parametrised multi-cycle RV32I-subset core, successor to the single-step LED demo CPU.
- Fetches 32-bit instructions over a valid/request port from an external ROM.
- Executes the ALU, LUI, branch and JAL subset, advancing one FSM state per enabled cycle.
- Drives the RGB LEDs from the low bits of the last written register.
- Sits under the board top, which supplies the slow step enable and the ROM.

Parameters:
XLEN, 32, datapath and register width
NREGS, 16, implemented registers x0..x(NREGS-1); 2..32
ROM_DEPTH, 16, instruction words addressable; PC width AW = $clog2(ROM_DEPTH)
LED_W, 3, register bits mirrored to LEDs

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
step_en  in  1  clock enable; all state updates qualified by it
imem_req  out  1  fetch request, high throughout FETCH
imem_addr  out  AW  word address (= PC)
imem_rdata  in  32  instruction word
imem_valid  in  1  rdata valid; held until consumed
led  out  LED_W  last written register [LED_W-1:0]; bit0=red, bit1=green, bit2=blue
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky; set by EBREAK
illegal  out  1  sticky; set by unsupported encoding
pc  out  AW  current PC (debug)

Behaviour:
- Reset (RST_N=0 at posedge, independent of step_en): PC=0, all regs=0, state=FETCH, led=0, retire=0, halted=0, illegal=0, imem_req=0 during reset cycle. imem_valid in that cycle is ignored; any outstanding fetch is dropped.
- FSM: FETCH -> EXEC -> FETCH; HALT is terminal until reset.
  - FETCH: imem_req=1. On step_en & imem_valid, latch IR and go to EXEC. No valid means stay; no timeout.
  - EXEC (on step_en): decode, compute, write rd, update PC, pulse retire, then go to FETCH, or to HALT on EBREAK (retire still pulses).
- Latency: at least 2 enabled cycles per instruction.
- step_en=0: all state and outputs hold; retire=0.
- Supported instructions:
  - R: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - Also: LUI, BEQ, BNE, BLT, BGE, JAL, EBREAK.
- Immediates are sign-extended to XLEN; shift amount = low $clog2(XLEN) bits.
- Arithmetic wraps modulo 2^XLEN.
- x0 reads 0 and writes to it are discarded. Reg index >= NREGS: reads 0, writes discarded.
- led updates only on an accepted write to rd != 0 with rd < NREGS; holds otherwise.
- PC:
  - Default next PC = PC+1 mod ROM_DEPTH.
  - Taken branch / JAL: PC + (offset>>2); offset bits [1:0] ignored; wraps mod ROM_DEPTH.
  - JAL writes rd = (PC+1)<<2.
- Unsupported opcode/funct: set illegal, no register write, PC+1. All-zero word is illegal.
- HALT: imem_req=0; PC, regs and led frozen; retire=0.

Optional Feature:
TINY_CPU_MUL_EN
- Defined: R-type funct7=0000001, funct3=000 is MUL, writing the low XLEN bits of rs1*rs2 in EXEC with the same latency.
- Undefined: that encoding is illegal (sets illegal, no write).

Decomposition:
- tiny_cpu_pkg: opcode constants (OP, OP_IMM, LUI, BRANCH, JAL, SYSTEM), funct3/funct7 codes, FSM state enum, ALU-op enum.
- Sub-module tiny_cpu_alu: combinational; ALU-op plus two XLEN operands to result and branch-compare flags. The MUL path lives inside it under the macro.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x0,3; ADD x3,x1,x2; ORI x5,x3,1 -> x3=8, x5=9, led=3'b001, retire count 4.
- ADDI x1,x0,-16; SRAI x2,x1,2; SRLI x3,x1,28; SLT x4,x1,x0 -> x2=0xFFFFFFFC, x3=0xF, x4=1.
- ADDI x1,x0,3; loop ADDI x1,x1,-1; BNE x1,x0,-4; EBREAK -> x1=0, halted=1, PC frozen at EBREAK word, imem_req=0.
- imem_valid delayed 3 cycles, then step_en toggled 1/0 -> state holds in FETCH; register results identical to the undelayed run.
- ADDI x0,x0,7 then word 0x00000000 -> x0=0, led unchanged, illegal=1, PC=2; RST_N low one cycle -> all outputs 0, refetch addr 0.
- x1=6, x2=7, MUL x3 -> macro on: x3=42; macro off: x3 unchanged, illegal=1.

Source files
------------

// File: rtl/tiny_cpu_pkg.sv
// Shared encodings, FSM states and ALU operations for the tiny multi-cycle RV32I-subset core.
package tiny_cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        ALU_PASSB
    } alu_op_t;

endpackage

// File: rtl/tiny_cpu_mc_if.sv
// Instruction fetch port between the core (master) and the external ROM (slave).
interface tiny_cpu_mc_if #(
    parameter int AW = 4
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          imem_valid;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/tiny_cpu_alu.sv
// Combinational ALU with branch-compare flags; the MUL path exists only when TINY_CPU_MUL_EN is defined.
module tiny_cpu_alu
    import tiny_cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t           i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [XLEN-1:0]   o_result,
    output logic              o_eq,
    output logic              o_lt
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;
    logic           w_lt;
    logic           w_ltu;

    assign w_shamt = i_b[SHW-1:0];
    assign w_lt    = $signed(i_a) < $signed(i_b);
    assign w_ltu   = i_a < i_b;
    assign o_eq    = (i_a == i_b);
    assign o_lt    = w_lt;

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
            ALU_SLT:   o_result = XLEN'(w_lt);
            ALU_SLTU:  o_result = XLEN'(w_ltu);
            ALU_PASSB: o_result = i_b;
`ifdef TINY_CPU_MUL_EN
            ALU_MUL:   o_result = i_a * i_b;
`endif
            default:   o_result = '0;
        endcase
    end
endmodule

// File: rtl/tiny_cpu_mc.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC per instruction, one state per enabled cycle.
// Optional MUL support is selected with the TINY_CPU_MUL_EN macro.
module tiny_cpu_mc
    import tiny_cpu_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NREGS     = 16,
    parameter  int ROM_DEPTH = 16,
    parameter  int LED_W     = 3,
    localparam int AW        = $clog2(ROM_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              step_en,
    tiny_cpu_mc_if.master     imem,
    output logic [LED_W-1:0]  led,
    output logic              retire,
    output logic              halted,
    output logic              illegal,
    output logic [AW-1:0]     pc
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t            r_state;
    logic [AW-1:0]     r_pc;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [LED_W-1:0]  r_led;
    logic              r_halted;
    logic              r_illegal;

    state_t            w_state_nxt;
    logic [6:0]        w_opc, w_f7;
    logic [4:0]        w_rd, w_rs1, w_rs2;
    logic [2:0]        w_f3;
    logic [XLEN-1:0]   w_rs1_val, w_rs2_val, w_imm_i, w_imm_u, w_alu_b, w_alu_res, w_wd;
    logic [31:0]       w_off;
    logic [AW-1:0]     w_pc_inc, w_pc_tgt, w_pc_next;
    alu_op_t           w_alu_op;
    logic              w_wr_en, w_wr_ok, w_ill, w_is_br, w_is_jal, w_is_ebreak, w_take;
    logic              w_eq, w_lt, w_unused;

    assign w_opc = r_ir[6:0];
    assign w_rd  = r_ir[11:7];
    assign w_f3  = r_ir[14:12];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_f7  = r_ir[31:25];

    assign w_imm_i = XLEN'($signed(r_ir[31:20]));
    assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));
    assign w_off   = w_is_jal ? 32'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}))
                              : 32'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
    // The PC counts words, so byte offset bits [1:0] and anything above the PC width drop out.
    assign w_unused = ^{w_off[31:AW+2], w_off[1:0]};

    assign w_rs1_val = (w_rs1 != 5'd0 && 32'(w_rs1) < NREGS) ? r_regs[w_rs1[RW-1:0]] : '0;
    assign w_rs2_val = (w_rs2 != 5'd0 && 32'(w_rs2) < NREGS) ? r_regs[w_rs2[RW-1:0]] : '0;

    tiny_cpu_alu #(.XLEN(XLEN)) u_alu (
        .i_op     (w_alu_op),
        .i_a      (w_rs1_val),
        .i_b      (w_alu_b),
        .o_result (w_alu_res),
        .o_eq     (w_eq),
        .o_lt     (w_lt)
    );

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_alu_b     = w_rs2_val;
        w_wr_en     = 1'b0;
        w_ill       = 1'b0;
        w_is_br     = 1'b0;
        w_is_jal    = 1'b0;
        w_is_ebreak = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_wr_en = 1'b1;
                case ({w_f7, w_f3})
                    {F7_BASE, F3_ADD}:  w_alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}:  w_alu_op = ALU_SUB;
                    {F7_BASE, F3_SLL}:  w_alu_op = ALU_SLL;
                    {F7_BASE, F3_SLT}:  w_alu_op = ALU_SLT;
                    {F7_BASE, F3_SLTU}: w_alu_op = ALU_SLTU;
                    {F7_BASE, F3_XOR}:  w_alu_op = ALU_XOR;
                    {F7_BASE, F3_SR}:   w_alu_op = ALU_SRL;
                    {F7_ALT,  F3_SR}:   w_alu_op = ALU_SRA;
                    {F7_BASE, F3_OR}:   w_alu_op = ALU_OR;
                    {F7_BASE, F3_AND}:  w_alu_op = ALU_AND;
`ifdef TINY_CPU_MUL_EN
                    {F7_MULDIV, F3_ADD}: w_alu_op = ALU_MUL;
`endif
                    default: begin
                        w_ill   = 1'b1;
                        w_wr_en = 1'b0;
                    end
                endcase
            end
            OPC_OP_IMM: begin
                w_wr_en = 1'b1;
                w_alu_b = w_imm_i;
                case (w_f3)
                    F3_ADD:  w_alu_op = ALU_ADD;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_AND:  w_alu_op = ALU_AND;
                    F3_SLL: begin
                        w_alu_op = ALU_SLL;
                        if (w_f7 != F7_BASE) begin
                            w_ill   = 1'b1;
                            w_wr_en = 1'b0;
                        end
                    end
                    default: begin
                        if (w_f7 == F7_BASE) w_alu_op = ALU_SRL;
                        else if (w_f7 == F7_ALT) w_alu_op = ALU_SRA;
                        else begin
                            w_ill   = 1'b1;
                            w_wr_en = 1'b0;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                w_wr_en  = 1'b1;
                w_alu_op = ALU_PASSB;
                w_alu_b  = w_imm_u;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    F3_BEQ, F3_BNE, F3_BLT, F3_BGE: w_is_br = 1'b1;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_JAL: begin
                w_wr_en  = 1'b1;
                w_is_jal = 1'b1;
            end
            OPC_SYSTEM: begin
                if (r_ir == INSN_EBREAK) w_is_ebreak = 1'b1;
                else w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (w_f3)
            F3_BEQ:  w_take = w_eq;
            F3_BNE:  w_take = !w_eq;
            F3_BLT:  w_take = w_lt;
            F3_BGE:  w_take = !w_lt;
            default: w_take = 1'b0;
        endcase
    end

    assign w_pc_inc  = r_pc + AW'(1);
    assign w_pc_tgt  = r_pc + w_off[AW+1:2];
    assign w_pc_next = (w_is_jal || (w_is_br && w_take)) ? w_pc_tgt : w_pc_inc;
    assign w_wd      = w_is_jal ? XLEN'({w_pc_inc, 2'b00}) : w_alu_res;
    assign w_wr_ok   = w_wr_en && (w_rd != 5'd0) && (32'(w_rd) < NREGS);

    always_comb begin
        w_state_nxt   = r_state;
        imem.imem_req = 1'b0;
        retire        = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem.imem_req = RST_N;
                if (step_en && imem.imem_valid) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                retire = RST_N && step_en;
                if (step_en) w_state_nxt = w_is_ebreak ? S_HALT : S_FETCH;
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_led     <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (step_en) begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH && imem.imem_valid) r_ir <= imem.imem_rdata;
            if (r_state == S_EXEC) begin
                // EBREAK leaves the PC on its own word so the debug view shows where it stopped.
                if (w_is_ebreak) r_halted <= 1'b1;
                else r_pc <= w_pc_next;
                if (w_ill) r_illegal <= 1'b1;
                if (w_wr_ok) begin
                    r_regs[w_rd[RW-1:0]] <= w_wd;
                    r_led                <= w_wd[LED_W-1:0];
                end
            end
        end
    end

    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;
    assign led            = r_led;
    assign halted         = r_halted;
    assign illegal        = r_illegal;
endmodule

// File: tb/tb_tiny_cpu_mc.sv
// Directed bench for tiny_cpu_mc: small programs in a behavioural ROM, hand-computed results.
module tb_tiny_cpu_mc;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        step_en = 1'b0;
    logic [2:0]  led;
    logic        retire, halted, illegal;
    logic [3:0]  pc;
    logic [31:0] rom [16];
    logic        gate = 1'b1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_ret = 0;
    int          base;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    tiny_cpu_mc_if #(.AW(4)) imem_bus ();

    tiny_cpu_mc #(.XLEN(32), .NREGS(16), .ROM_DEPTH(16), .LED_W(3)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .step_en (step_en),
        .imem    (imem_bus),
        .led     (led),
        .retire  (retire),
        .halted  (halted),
        .illegal (illegal),
        .pc      (pc)
    );

    assign imem_bus.imem_rdata = rom[imem_bus.imem_addr];
    assign imem_bus.imem_valid = imem_bus.imem_req & gate;

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (retire === 1'b1) n_ret++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1, input int f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], rs2[4:0], rs1[4:0], f3[2:0], o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off, input int rd);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    endtask

    task automatic do_reset();
        step_en = 1'b1;
        RST_N   = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        tick();
        RST_N   = 1'b1;
        step_en = 1'b0;
        #1;
        chk("rst_pc", {28'b0, pc}, 32'd0);
        chk("rst_addr", {28'b0, imem_bus.imem_addr}, 32'd0);
        chk("rst_led", {29'b0, led}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        base = n_ret;
    endtask

    task automatic run_n(input int n);
        step_en = 1'b1;
        repeat (n) tick();
        step_en = 1'b0;
    endtask

    task automatic run_until_halt(input string tag, input int budget);
        step_en = 1'b1;
        for (int c = 0; c < budget && halted !== 1'b1; c++) tick();
        step_en = 1'b0;
        chk(tag, {31'b0, halted}, 32'd1);
    endtask

    task automatic load_prog1();
        clear_rom();
        rom[0] = enc_i(5, 0, 0, 1, 7'h13);
        rom[1] = enc_i(3, 0, 0, 2, 7'h13);
        rom[2] = enc_r(0, 2, 1, 0, 3);
        rom[3] = enc_i(1, 3, 6, 5, 7'h13);
    endtask

    initial begin
        clear_rom();
        do_reset();

        // ALU basics, fixed 8 enabled cycles = 4 instructions
        load_prog1();
        do_reset();
        run_n(8);
        chk("p1_x3", dut.r_regs[3], 32'd8);
        chk("p1_x5", dut.r_regs[5], 32'd9);
        chk("p1_led", {29'b0, led}, 32'b001);
        chk("p1_retire", n_ret - base, 32'd4);
        chk("p1_pc", {28'b0, pc}, 32'd4);

        // Shifts and signed compare
        clear_rom();
        rom[0] = enc_i(-16, 0, 0, 1, 7'h13);
        rom[1] = enc_i(12'h402, 1, 5, 2, 7'h13);
        rom[2] = enc_i(28, 1, 5, 3, 7'h13);
        rom[3] = enc_r(0, 0, 1, 2, 4);
        rom[4] = EBREAK;
        do_reset();
        run_until_halt("p2_halt", 40);
        chk("p2_x1", dut.r_regs[1], 32'hFFFF_FFF0);
        chk("p2_x2", dut.r_regs[2], 32'hFFFF_FFFC);
        chk("p2_x3", dut.r_regs[3], 32'h0000_000F);
        chk("p2_x4", dut.r_regs[4], 32'd1);
        chk("p2_led", {29'b0, led}, 32'b001);

        // Countdown loop with BNE, then EBREAK
        clear_rom();
        rom[0] = enc_i(3, 0, 0, 1, 7'h13);
        rom[1] = enc_i(-1, 1, 0, 1, 7'h13);
        rom[2] = enc_b(-4, 0, 1, 1);
        rom[3] = EBREAK;
        do_reset();
        run_until_halt("p3_halt", 60);
        chk("p3_x1", dut.r_regs[1], 32'd0);
        chk("p3_pc", {28'b0, pc}, 32'd3);
        chk("p3_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("p3_retire", n_ret - base, 32'd8);
        run_n(4);
        chk("p3_pc_frozen", {28'b0, pc}, 32'd3);
        chk("p3_retire_frozen", n_ret - base, 32'd8);

        // Late imem_valid, then step_en toggling
        load_prog1();
        do_reset();
        gate    = 1'b0;
        step_en = 1'b1;
        repeat (3) tick();
        chk("p4_wait_pc", {28'b0, pc}, 32'd0);
        chk("p4_wait_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("p4_wait_retire", n_ret - base, 32'd0);
        gate = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step_en = 1'b1;
            tick();
            step_en = 1'b0;
            #1;
            if (k == 1) chk("p4_hold_retire", {31'b0, retire}, 32'd0);
            tick();
        end
        chk("p4_x3", dut.r_regs[3], 32'd8);
        chk("p4_x5", dut.r_regs[5], 32'd9);
        chk("p4_pc", {28'b0, pc}, 32'd4);
        chk("p4_retire", n_ret - base, 32'd4);

        // Write to x0 and all-zero illegal word, then reset mid-stream
        clear_rom();
        rom[0] = enc_i(7, 0, 0, 0, 7'h13);
        do_reset();
        run_n(4);
        chk("p5_x0", dut.r_regs[0], 32'd0);
        chk("p5_led", {29'b0, led}, 32'd0);
        chk("p5_illegal", {31'b0, illegal}, 32'd1);
        chk("p5_pc", {28'b0, pc}, 32'd2);
        do_reset();
        chk("p5_refetch_req", {31'b0, imem_bus.imem_req}, 32'd1);

        // MUL encoding
        clear_rom();
        rom[0] = enc_i(6, 0, 0, 1, 7'h13);
        rom[1] = enc_i(7, 0, 0, 2, 7'h13);
        rom[2] = enc_r(1, 2, 1, 0, 3);
        rom[3] = EBREAK;
        do_reset();
        run_until_halt("p6_halt", 40);
`ifdef TINY_CPU_MUL_EN
        chk("p6_x3", dut.r_regs[3], 32'd42);
        chk("p6_illegal", {31'b0, illegal}, 32'd0);
        chk("p6_led", {29'b0, led}, 32'b010);
`else
        chk("p6_x3", dut.r_regs[3], 32'd0);
        chk("p6_illegal", {31'b0, illegal}, 32'd1);
        chk("p6_led", {29'b0, led}, 32'b111);
`endif

        // JAL link and skip, BLT not taken
        clear_rom();
        rom[0] = enc_j(8, 1);
        rom[1] = enc_i(1, 0, 0, 2, 7'h13);
        rom[2] = enc_b(8, 0, 1, 4);
        rom[3] = EBREAK;
        do_reset();
        run_until_halt("p7_halt", 40);
        chk("p7_x1", dut.r_regs[1], 32'd4);
        chk("p7_x2", dut.r_regs[2], 32'd0);
        chk("p7_pc", {28'b0, pc}, 32'd3);
        chk("p7_led", {29'b0, led}, 32'b100);

        // PC wrap in both directions, LUI
        clear_rom();
        rom[0]  = enc_j(-4, 0);
        rom[15] = enc_j(8, 0);
        rom[1]  = enc_i(-1, 0, 0, 7, 7'h13);
        rom[2]  = {20'h80001, 5'd8, 7'h37};
        rom[3]  = EBREAK;
        do_reset();
        run_until_halt("p8_halt", 40);
        chk("p8_x7", dut.r_regs[7], 32'hFFFF_FFFF);
        chk("p8_x8", dut.r_regs[8], 32'h8000_1000);
        chk("p8_pc", {28'b0, pc}, 32'd3);
        chk("p8_led", {29'b0, led}, 32'b000);
        chk("p8_illegal", {31'b0, illegal}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
